// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the execute stage and the multiply/divide
// sequencer.
//   start, op, a, b        : request (core -> sequencer)
//   busy, done             : status  (sequencer -> core)
//   hi, lo, div_by_zero    : result  (sequencer -> core)
// master = core side, slave = sequencer side.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply / divide sequencer.
// Borrows the core's 32-bit ALU for every add/subtract: one ALU operation per
// clock, WIDTH iterations of shift-and-add multiply or restoring divide.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : start/op/a/b request, busy/done status, hi/lo/div_by_zero
//                     result (MUL: {hi,lo}=product, DIV: hi=rem, lo=quot)
//   alu_a/alu_b     : ALU operands (driven from registers only)
//   alu_op          : ALU opcode (ALU_ADD for multiply/idle, ALU_SUB for divide)
//   alu_r/alu_c     : ALU result and carry (add: carry-out, sub: borrow)
module muldiv_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_seq_if.slave      bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_c
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             op_q;
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;

    // Divide step: shifted partial remainder and its dropped top bit.
    logic             div_m;
    logic [WIDTH-1:0] div_s;
    logic             div_q;

    assign div_m = hi[WIDTH-1];
    assign div_s = {hi[WIDTH-2:0], lo[WIDTH-1]};
    // With m=1 the true remainder is >= 2^WIDTH > divisor, so subtract always
    // succeeds and the wrapped ALU result is the exact new remainder.
    assign div_q = div_m | ~alu_c;

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == FIN);
    assign bus.hi          = hi;
    assign bus.lo          = lo;
    assign bus.div_by_zero = dbz;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        if (state == RUN) begin
            if (!op_q) begin
                alu_a  = hi;
                alu_b  = lo[0] ? opnd : '0;
                alu_op = ALU_ADD;
            end else begin
                alu_a  = div_s;
                alu_b  = opnd;
                alu_op = ALU_SUB;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            op_q  <= 1'b0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        opnd  <= bus.b;
                        count <= '0;
                        dbz   <= 1'b0;
                        if (bus.op && (bus.b == '0)) begin
                            // Divide by zero: finish at once with MIPS-like result.
                            hi    <= bus.a;
                            lo    <= '1;
                            dbz   <= 1'b1;
                            state <= FIN;
                        end else begin
                            hi    <= '0;
                            lo    <= bus.a;
                            state <= RUN;
                        end
                    end else if (state == FIN) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (!op_q) begin
                        // 65-bit {carry, sum, lo} shifted right by one.
                        {hi, lo} <= {alu_c, alu_r, lo[WIDTH-1:1]};
                    end else begin
                        hi <= div_q ? alu_r : div_s;
                        lo <= {lo[WIDTH-2:0], div_q};
                    end
                    if (count == LAST) begin
                        state <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed and random multiply/divide requests,
// expected results queued at issue time and checked by a monitor on done.
module tb_muldiv_seq;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_op;
    logic        alu_c;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .ALU_ADD(ADD), .ALU_SUB(SUB)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_r  (alu_r),
        .alu_c  (alu_c)
    );

    // Behavioural model of the shared ALU.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        case (alu_op)
            ADD: {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
            SUB: begin
                alu_r = alu_a - alu_b;
                alu_c = (alu_a < alu_b);
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic [3:0]  aop;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_cnt = 0;
    int   aop_bad  = 0;
    int   idle_bad = 0;
    int   done_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the oldest expectation whenever done is presented.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            aop_bad  = 0;
            if (bus.done) chk("done_in_reset", 64'(bus.done), 64'd0);
        end else begin
            if (bus.busy) begin
                busy_cnt++;
                if (exp_q.size() == 0 || alu_op !== exp_q[0].aop) aop_bad++;
            end else if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== ADD) begin
                idle_bad++;
            end
            if (bus.done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("hi", 64'(bus.hi), 64'(e.hi));
                    chk("lo", 64'(bus.lo), 64'(e.lo));
                    chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
                    chk("alu_op_in_run", 64'(aop_bad), 64'd0);
                end
                busy_cnt = 0;
                aop_bad  = 0;
            end
        end
    end

    // Reference model: plain arithmetic on the request operands.
    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        if (!o) begin
            p = {32'd0, x} * {32'd0, y};
            e.hi = p[63:32]; e.lo = p[31:0]; e.dbz = 1'b0; e.aop = ADD; e.cycles = 32;
        end else if (y == 32'd0) begin
            e.hi = x; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1; e.aop = SUB; e.cycles = 0;
        end else begin
            e.hi = x % y; e.lo = x / y; e.dbz = 1'b0; e.aop = SUB; e.cycles = 32;
        end
        return e;
    endfunction

    // Present a request for one edge, then scramble the operands.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        last_exp = model(o, x, y);
        exp_q.push_back(last_exp);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 80 && !bus.done; i++) begin
            @(posedge clk); #1;
        end
        chk("done_within_budget", 64'(bus.done), 64'd1);
    endtask

    task automatic run(input logic o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y);
        wait_done();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed multiply / divide cases.
        run(1'b0, 32'd7, 32'd6);
        run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run(1'b0, 32'h80000000, 32'd2);
        run(1'b1, 32'd100, 32'd7);
        run(1'b1, 32'hFFFFFFFF, 32'h80000001);
        run(1'b1, 32'd5, 32'd9);

        // Divide by zero: done right after accept, then a multiply clears the flag.
        issue(1'b1, 32'h1234, 32'd0);
        chk("dbz_done_next_cycle", 64'(bus.done), 64'd1);
        chk("dbz_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        issue(1'b0, 32'd9, 32'd9);
        chk("dbz_cleared_at_accept", 64'(bus.div_by_zero), 64'd0);
        wait_done();
        @(posedge clk); #1;

        // Result hold while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_hi", 64'(bus.hi), 64'(last_exp.hi));
        chk("hold_lo", 64'(bus.lo), 64'(last_exp.lo));

        // start held through RUN must be accepted once only.
        last_exp = model(1'b0, 32'd1234, 32'd5678);
        exp_q.push_back(last_exp);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd1234; bus.b = 32'd5678;
        repeat (20) @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done();
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("single_accept_busy", 64'(bus.busy), 64'd0);

        // Back-to-back: new request in the FIN cycle, incl. divide-by-zero chains.
        issue(1'b1, 32'd1000, 32'd33);
        wait_done();
        issue(1'b0, 32'hDEADBEEF, 32'h12345678);
        wait_done();
        issue(1'b1, 32'd77, 32'd0);
        wait_done();
        issue(1'b1, 32'd55, 32'd0);
        wait_done();
        issue(1'b1, 32'hCAFEF00D, 32'd3);
        wait_done();
        @(posedge clk); #1;

        // Reset after the 10th step aborts without a done pulse.
        exp_q.push_back(model(1'b0, 32'hABCDEF01, 32'h13579BDF));
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'hABCDEF01; bus.b = 32'h13579BDF;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run(1'b0, 32'd3, 32'd5);

        // Random mix.
        for (int i = 0; i < 40; i++) begin
            logic        o;
            logic [31:0] x, y;
            o = 1'($urandom);
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1, 2:    y = $urandom_range(1, 255);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                issue(o, x, y);
                wait_done();
            end else begin
                run(o, x, y);
            end
        end
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("idle_alu_drive", 64'(idle_bad), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer that reuses the existing 32-bit ALU (add 4'b0010, sub 4'b0110) as its only adder/subtractor.
- Runs shift-and-add multiply or restoring divide, one ALU operation per clock, 32 iterations.
- Sits beside the execute stage; the core stalls on busy and takes hi/lo on done.

Parameters:
- WIDTH, 32, operand width; only 32 is verified; iteration counter is $clog2(WIDTH) bits.
- ALU_ADD, 4'b0010, ALU opcode driven for multiply steps.
- ALU_SUB, 4'b0110, ALU opcode driven for divide steps.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on an edge where busy=0.
- op  in  1  0 = unsigned multiply, 1 = unsigned divide; sampled at accept.
- a  in  32  multiplicand / dividend; sampled at accept.
- b  in  32  multiplier / divisor; sampled at accept.
- busy  out  1  high while state=RUN.
- done  out  1  high for exactly one cycle (state=FIN); hi/lo/div_by_zero valid.
- hi  out  32  MUL: product[63:32]; DIV: remainder.
- lo  out  32  MUL: product[31:0]; DIV: quotient.
- div_by_zero  out  1  set when the accepted divide had b=0; cleared at next accept.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  4  ALU opcode.
- alu_r  in  32  ALU result.
- alu_c  in  1  ALU carry: add = carry-out; sub = borrow (1 when A<B unsigned).

Behaviour:
- Reset: state=IDLE, count=0, hi=lo=0, operand register=0, div_by_zero=0. Outputs: busy=0, done=0. All asynchronous.
- States: IDLE, RUN, FIN. busy=(state==RUN) and done=(state==FIN), both decoded from the state register (glitch-free).
- Accept: on an edge with start=1 in IDLE or FIN, the block latches op and stores b in the operand register (mcand/divisor). count<=0, div_by_zero<=0.
  - MUL: hi<=0, lo<=b... no swap: hi<=0, lo<=a, operand register<=b; state<=RUN.
  - DIV, b!=0: hi<=0, lo<=a; state<=RUN.
  - DIV, b=0: hi<=a, lo<=32'hFFFFFFFF, div_by_zero<=1; state<=FIN (no iterations).
- FIN without start: FIN->IDLE. FIN with start: accepted (back-to-back allowed).
- start in RUN: ignored. a/b/op changes while busy: no effect.
- MUL step (each RUN edge):
  - Drive alu_a=hi, alu_b=lo[0] ? mcand : 0, alu_op=ALU_ADD.
  - Update {hi,lo} <= {alu_c, alu_r, lo[31:1]} (a 65-bit value shifted right by one).
- DIV step (each RUN edge):
  - Let m=hi[31], s={hi[30:0], lo[31]}. Drive alu_a=s, alu_b=divisor, alu_op=ALU_SUB.
  - If m=1 or alu_c=0: hi<=alu_r, q=1 (mod-2^32 result is exact when m=1).
  - Else: hi<=s, q=0.
  - Update lo<={lo[30:0], q}.
- Iteration count: count increments each RUN edge. The edge with count==31 performs the last step and sets state<=FIN.
- Timing: accept at edge E0, steps at E1..E32, done high between E32 and E33. Divide-by-zero: done high between E0 and E1.
- Idle ALU drive: outside RUN, alu_a=alu_b=0 and alu_op=ALU_ADD. alu_* are combinational from registers only (no path from start/a/b).
- Result hold: hi, lo, div_by_zero hold after FIN until the next accept or reset.
- Reset mid-operation: abort immediately to reset values; done does not pulse.

Test Plan:
- MUL a=7, b=6, start at E0 -> busy E0..E32; done one cycle after E32 with hi=0, lo=42; alu_op=4'b0010 throughout RUN.
- MUL a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. MUL a=32'h80000000, b=2 -> hi=1, lo=0.
- DIV 100/7 -> lo=14, hi=2. DIV 32'hFFFFFFFF/32'h80000001 (m=1 path) -> lo=1, hi=32'h7FFFFFFE. DIV 5/9 -> lo=0, hi=5. alu_op=4'b0110 during RUN.
- DIV a=32'h1234, b=0 -> done one cycle after accept, busy never high; lo=32'hFFFFFFFF, hi=32'h1234, div_by_zero=1. A following MUL clears div_by_zero.
- Protocol: start held high through RUN -> only one accept. start in FIN cycle -> new op accepted with no IDLE gap, and the new result is correct.
- rst pulsed after the 10th step -> busy=0, hi=lo=0, no done pulse. A subsequent MUL 3x5 -> lo=15.
